icache_direct: RTL and testbench

- Direct-mapped, one-word-per-block instruction cache.
- Sits directly downstream of the pipelined datapath fetch stage. It consumes imemaddr/imemREN and returns imemload/ihit.
- On a miss it fetches the word from the memory controller through an iREN/iaddr/iwait/iload handshake.
- Read-only: no write path and no dirty state.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/icache_frame_array.sv | 43 ++++
 rtl/icache_direct.sv | 89 ++++++++
 tb/tb_icache_direct.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared instruction-cache types: address field view, default geometry constants and FSM states.
package cpu_types_pkg;

  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the direct-mapped icache: one combinational read port, one synchronous write port.
module icache_frame_array #(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             sRST,
  input  logic [IDX_W-1:0] idx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata
);

  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tags  [NSETS];
  logic [31:0]      words [NSETS];

  // Only the valid bits need clearing; stale tag/data behind a cleared valid bit is harmless.
  always_ff @(posedge CLK) begin
    if (sRST) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (we && !sRST) begin
      tags[widx]  <= wtag;
      words[widx] <= wdata;
    end
  end

  assign rvalid = valid[idx];
  assign rtag   = tags[idx];
  assign rdata  = words[idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with zero-latency hits and a single-word miss fill.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        sRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_state_t state;
  logic [31:0]   miss_addr;

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             rvalid;
  logic [TAG_W-1:0] rtag;
  logic [31:0]      rdata;
  logic             hit;
  logic             fill_we;

  assign look_idx = imemaddr[IDX_W+1:2];
  assign look_tag = imemaddr[31:IDX_W+2];

  // Lookups are only honoured in IDLE so the datapath never sees a hit while a fill is outstanding.
  assign hit      = (state == IDLE) && imemREN && rvalid && (rtag == look_tag);
  assign ihit     = hit;
  assign imemload = hit ? rdata : 32'h0;

  assign fill_we = (state == FETCH) && !iwait && !sRST;
  assign iaddr   = word_align(miss_addr);

  icache_frame_array #(
    .NSETS(NSETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_frames (
    .CLK   (CLK),
    .sRST  (sRST),
    .idx   (look_idx),
    .rvalid(rvalid),
    .rtag  (rtag),
    .rdata (rdata),
    .we    (fill_we),
    .widx  (miss_addr[IDX_W+1:2]),
    .wtag  (miss_addr[31:IDX_W+2]),
    .wdata (iload)
  );

  always_ff @(posedge CLK) begin
    if (sRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
      iREN      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            state     <= FETCH;
            miss_addr <= imemaddr;
            iREN      <= 1'b1;
          end
        end
        FETCH: begin
          // The fill completes for the latched address even if the datapath has moved on.
          if (!iwait) begin
            state <= IDLE;
            iREN  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          iREN  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct with a hand-driven memory controller.
module tb_icache_direct;

  logic        CLK;
  logic        sRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int errors;
  int checks;

  icache_direct #(.NSETS(16)) dut (
    .CLK     (CLK),
    .sRST    (sRST),
    .imemREN (imemREN),
    .imemaddr(imemaddr),
    .ihit    (ihit),
    .imemload(imemload),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] load);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = load;
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled 2ns later.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Full miss on addr: miss cycle, nwait busy FETCH cycles, a ready cycle, then the hit cycle.
  task automatic doMiss(input logic [31:0] addr, input logic [31:0] data, input int nwait);
    tick;
    applyStimulus(1'b1, addr, 1'b1, 32'h0);
    #2;
    checkOutput("miss_ihit", {31'b0, ihit}, 32'h0);
    checkOutput("miss_iren", {31'b0, iREN}, 32'h0);
    for (int i = 0; i < nwait; i++) begin
      tick;
      #2;
      checkOutput("fetch_iren", {31'b0, iREN}, 32'h1);
      checkOutput("fetch_iaddr", iaddr, addr);
      checkOutput("fetch_ihit", {31'b0, ihit}, 32'h0);
    end
    tick;
    iwait = 1'b0;
    iload = data;
    #2;
    checkOutput("ready_iren", {31'b0, iREN}, 32'h1);
    checkOutput("ready_iaddr", iaddr, addr);
    tick;
    iwait = 1'b1;
    iload = 32'h0;
    #2;
    checkOutput("fill_ihit", {31'b0, ihit}, 32'h1);
    checkOutput("fill_load", imemload, data);
    checkOutput("fill_iren", {31'b0, iREN}, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sRST = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    tick;
    tick;
    sRST = 1'b0;
    #2;
    checkOutput("rst_ihit", {31'b0, ihit}, 32'h0);
    checkOutput("rst_iren", {31'b0, iREN}, 32'h0);
    checkOutput("rst_iaddr", iaddr, 32'h0);
    checkOutput("rst_load", imemload, 32'h0);

    // Cold miss with two wait cycles, then warm hit.
    doMiss(32'h0000_0040, 32'h8C22_0004, 2);
    tick;
    #2;
    checkOutput("warm_ihit", {31'b0, ihit}, 32'h1);
    checkOutput("warm_load", imemload, 32'h8C22_0004);
    checkOutput("warm_iren", {31'b0, iREN}, 32'h0);

    // Conflict eviction: 0x440 shares index 0 with 0x40.
    doMiss(32'h0000_0440, 32'hAAAA_0440, 1);
    doMiss(32'h0000_0040, 32'h8C22_0004, 0);

    // Address change mid-FETCH: 0x80 fill completes, 0x84 misses afterwards.
    tick;
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0);
    #2;
    checkOutput("chg_miss", {31'b0, ihit}, 32'h0);
    tick;
    imemaddr = 32'h0000_0084;
    #2;
    checkOutput("chg_iaddr", iaddr, 32'h0000_0080);
    checkOutput("chg_ihit", {31'b0, ihit}, 32'h0);
    tick;
    iwait = 1'b0;
    iload = 32'h1111_1111;
    #2;
    checkOutput("chg_ready_iaddr", iaddr, 32'h0000_0080);
    tick;
    iwait = 1'b1;
    iload = 32'h0;
    #2;
    checkOutput("chg_84_miss", {31'b0, ihit}, 32'h0);
    checkOutput("chg_84_load", imemload, 32'h0);
    tick;
    #2;
    checkOutput("chg_84_iaddr", iaddr, 32'h0000_0084);
    iwait = 1'b0;
    iload = 32'h2222_2222;
    tick;
    iwait = 1'b1;
    iload = 32'h0;
    #2;
    checkOutput("chg_84_hit", {31'b0, ihit}, 32'h1);
    checkOutput("chg_84_data", imemload, 32'h2222_2222);
    tick;
    imemaddr = 32'h0000_0080;
    #2;
    checkOutput("chg_80_hit", {31'b0, ihit}, 32'h1);
    checkOutput("chg_80_data", imemload, 32'h1111_1111);

    // Reset mid-FETCH: no lookup during FETCH, and the ready-cycle fill is dropped.
    tick;
    applyStimulus(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    #2;
    checkOutput("rf_miss", {31'b0, ihit}, 32'h0);
    tick;
    imemaddr = 32'h0000_0084;
    #2;
    checkOutput("rf_nolookup", {31'b0, ihit}, 32'h0);
    checkOutput("rf_iren", {31'b0, iREN}, 32'h1);
    tick;
    sRST = 1'b1;
    applyStimulus(1'b1, 32'h0000_00C0, 1'b0, 32'h3333_3333);
    tick;
    sRST = 1'b0;
    iwait = 1'b1;
    iload = 32'h0;
    #2;
    checkOutput("rf_iren_off", {31'b0, iREN}, 32'h0);
    checkOutput("rf_c0_miss", {31'b0, ihit}, 32'h0);
    tick;
    #2;
    checkOutput("rf_refetch_iren", {31'b0, iREN}, 32'h1);
    checkOutput("rf_refetch_iaddr", iaddr, 32'h0000_00C0);
    iwait = 1'b0;
    iload = 32'h4444_4444;
    tick;
    iwait = 1'b1;
    iload = 32'h0;
    #2;
    checkOutput("rf_c0_hit", {31'b0, ihit}, 32'h1);
    checkOutput("rf_c0_data", imemload, 32'h4444_4444);

    // imemREN low on a valid frame's address.
    tick;
    applyStimulus(1'b0, 32'h0000_00C0, 1'b1, 32'h0);
    #2;
    checkOutput("noren_ihit", {31'b0, ihit}, 32'h0);
    checkOutput("noren_load", imemload, 32'h0);
    checkOutput("noren_iren", {31'b0, iREN}, 32'h0);
    tick;
    #2;
    checkOutput("noren_iren2", {31'b0, iREN}, 32'h0);
    imemREN = 1'b1;
    #1;
    checkOutput("noren_then_hit", {31'b0, ihit}, 32'h1);
    imemaddr = 32'h0000_0084;
    #1;
    checkOutput("rst_cleared_84", {31'b0, ihit}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
